// File: rtl/zbb_pkg.sv
// zbb_pkg: opcode, forwarding-select, FSM types and count-width helper shared by the Zbb execute unit
package zbb_pkg;

   typedef enum logic [4:0] {
      OP_NOP   = 5'd0,
      OP_CLZ   = 5'd1,
      OP_CTZ   = 5'd2,
      OP_CPOP  = 5'd3,
      OP_MINU  = 5'd4,
      OP_MAXU  = 5'd5,
      OP_SEXTH = 5'd6,
      OP_SEXTB = 5'd7,
      OP_MAX   = 5'd8,
      OP_MIN   = 5'd9,
      OP_ZEXTH = 5'd10,
      OP_ROL   = 5'd11,
      OP_ROR   = 5'd12,
      OP_RORI  = 5'd13,
      OP_ORCB  = 5'd14,
      OP_REV8  = 5'd15,
      OP_CPOP2 = 5'd16,
      OP_ANDN  = 5'd17,
      OP_ORN   = 5'd18,
      OP_XNOR  = 5'd19
   } zbb_op_e;

   localparam logic [1:0] FWD_RS     = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;
   localparam logic [1:0] FWD_ZERO   = 2'b11;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_COUNT = 1'b1
   } zbb_state_e;

   function automatic int cnt_w(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

endpackage

// File: rtl/zbb_exec_unit_bitcount.sv
// zbb_bitcount: clz/ctz/cpop of one word; halves are counted and registered on load, merged the next cycle
module zbb_bitcount
   import zbb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     ld_i,
   input  logic [XLEN-1:0]          a_i,
   output logic [cnt_w(XLEN)-1:0]   clz_o,
   output logic [cnt_w(XLEN)-1:0]   ctz_o,
   output logic [cnt_w(XLEN)-1:0]   cpop_o
);

   localparam int H  = XLEN / 2;
   localparam int HW = cnt_w(H);
   localparam int CW = cnt_w(XLEN);

   logic [H-1:0]  w_hi, w_lo;
   logic [HW-1:0] w_hi_clz, w_lo_clz, w_hi_ctz, w_lo_ctz, w_hi_pop, w_lo_pop;
   logic [HW-1:0] r_hi_clz, r_lo_clz, r_hi_ctz, r_lo_ctz, r_hi_pop, r_lo_pop;

   assign w_hi = a_i[XLEN-1:H];
   assign w_lo = a_i[H-1:0];

   // later iterations win, so clz keeps the highest set bit and ctz the lowest
   always_comb begin
      w_hi_clz = HW'(H);
      w_lo_clz = HW'(H);
      w_hi_ctz = HW'(H);
      w_lo_ctz = HW'(H);
      w_hi_pop = '0;
      w_lo_pop = '0;
      for (int i = 0; i < H; i++) begin
         if (w_hi[i]) w_hi_clz = HW'(H - 1 - i);
         if (w_lo[i]) w_lo_clz = HW'(H - 1 - i);
         if (w_hi[H-1-i]) w_hi_ctz = HW'(H - 1 - i);
         if (w_lo[H-1-i]) w_lo_ctz = HW'(H - 1 - i);
         w_hi_pop = w_hi_pop + HW'(w_hi[i]);
         w_lo_pop = w_lo_pop + HW'(w_lo[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_hi_clz <= '0;
         r_lo_clz <= '0;
         r_hi_ctz <= '0;
         r_lo_ctz <= '0;
         r_hi_pop <= '0;
         r_lo_pop <= '0;
      end else if (ld_i) begin
         r_hi_clz <= w_hi_clz;
         r_lo_clz <= w_lo_clz;
         r_hi_ctz <= w_hi_ctz;
         r_lo_ctz <= w_lo_ctz;
         r_hi_pop <= w_hi_pop;
         r_lo_pop <= w_lo_pop;
      end
   end

   assign clz_o  = (r_hi_clz == HW'(H)) ? CW'(H) + CW'(r_lo_clz) : CW'(r_hi_clz);
   assign ctz_o  = (r_lo_ctz == HW'(H)) ? CW'(H) + CW'(r_hi_ctz) : CW'(r_lo_ctz);
   assign cpop_o = CW'(r_hi_pop) + CW'(r_lo_pop);

endmodule

// File: rtl/zbb_exec_unit.sv
// zbb_exec_unit: handshaked Zbb execute stage; rol/ror/rori are built only when ZBB_ROT_EN is defined
module zbb_exec_unit
   import zbb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [4:0]       op_i,
   input  logic [31:0]      instr_word_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  rs2_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [XLEN-1:0]  ex_mem_i,
   input  logic [XLEN-1:0]  mem_wb_i,
   input  logic [1:0]       fwd_a_sel_i,
   input  logic [1:0]       fwd_b_sel_i,
   input  logic             imm_sel_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  res_o,
   output logic             illegal_o
);

   localparam int CNT_W = cnt_w(XLEN);
   localparam int SW    = $clog2(XLEN);

   zbb_state_e         r_state, w_state_nxt;
   logic [4:0]         r_cnt_op;
   logic               r_valid, r_ill;
   logic [XLEN-1:0]    r_res;
   logic [XLEN-1:0]    w_op1, w_op2_pre, w_op2, w_alu, w_orc, w_rev;
   logic               w_alu_ill, w_is_cnt, w_accept, w_drain_ok, w_load;
   logic [CNT_W-1:0]   w_clz, w_ctz, w_cpop, w_cnt_res;
   logic               w_unused;

   assign w_op1 = (fwd_a_sel_i == FWD_RS)     ? rs1_i    :
                  (fwd_a_sel_i == FWD_MEM_WB) ? mem_wb_i :
                  (fwd_a_sel_i == FWD_EX_MEM) ? ex_mem_i : '0;
   assign w_op2_pre = (fwd_b_sel_i == FWD_RS)     ? rs2_i    :
                      (fwd_b_sel_i == FWD_MEM_WB) ? mem_wb_i :
                      (fwd_b_sel_i == FWD_EX_MEM) ? ex_mem_i : '0;
   assign w_op2 = imm_sel_i ? imm_i : w_op2_pre;

   assign w_is_cnt = (op_i == OP_CLZ) || (op_i == OP_CTZ) || (op_i == OP_CPOP) || (op_i == OP_CPOP2);
   assign w_accept = valid_i && ready_o;

   zbb_bitcount #(.XLEN(XLEN)) u_bitcount (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .ld_i   (w_accept && w_is_cnt),
      .a_i    (w_op1),
      .clz_o  (w_clz),
      .ctz_o  (w_ctz),
      .cpop_o (w_cpop)
   );

   assign w_cnt_res = (r_cnt_op == OP_CLZ) ? w_clz : (r_cnt_op == OP_CTZ) ? w_ctz : w_cpop;

`ifdef ZBB_ROT_EN
   logic [SW-1:0]      w_rot_sh;
   logic [2*XLEN-1:0]  w_rol_full, w_ror_full;
   // rotating a doubled word keeps shift 0 well defined without a width-sized shift
   assign w_rot_sh   = (op_i == OP_RORI) ? instr_word_i[20 +: SW] : w_op2[SW-1:0];
   assign w_rol_full = {w_op1, w_op1} << w_rot_sh;
   assign w_ror_full = {w_op1, w_op1} >> w_rot_sh;
   assign w_unused   = ^{instr_word_i, w_rol_full[XLEN-1:0], w_ror_full[2*XLEN-1:XLEN]};
`else
   assign w_unused   = ^instr_word_i;
`endif

   always_comb begin
      w_orc = '0;
      w_rev = '0;
      for (int b = 0; b < XLEN / 8; b++) begin
         w_orc[8*b +: 8] = {8{|w_op1[8*b +: 8]}};
         w_rev[8*b +: 8] = w_op1[XLEN-8-8*b +: 8];
      end
   end

   always_comb begin
      w_alu     = '0;
      w_alu_ill = 1'b0;
      case (op_i)
         OP_NOP, OP_CLZ, OP_CTZ, OP_CPOP, OP_CPOP2: w_alu = '0;
         OP_MINU:  w_alu = (w_op2 < w_op1) ? w_op2 : w_op1;
         OP_MAXU:  w_alu = (w_op2 > w_op1) ? w_op2 : w_op1;
         OP_MIN:   w_alu = ($signed(w_op2) < $signed(w_op1)) ? w_op2 : w_op1;
         OP_MAX:   w_alu = ($signed(w_op2) > $signed(w_op1)) ? w_op2 : w_op1;
         OP_SEXTH: w_alu = {{(XLEN-16){w_op1[15]}}, w_op1[15:0]};
         OP_SEXTB: w_alu = {{(XLEN-8){w_op1[7]}}, w_op1[7:0]};
         OP_ZEXTH: w_alu = {{(XLEN-16){1'b0}}, w_op1[15:0]};
`ifdef ZBB_ROT_EN
         OP_ROL:          w_alu = w_rol_full[2*XLEN-1:XLEN];
         OP_ROR, OP_RORI: w_alu = w_ror_full[XLEN-1:0];
`endif
         OP_ORCB:  w_alu = w_orc;
         OP_REV8:  w_alu = w_rev;
         OP_ANDN:  w_alu = w_op1 & ~w_op2;
         OP_ORN:   w_alu = w_op1 | ~w_op2;
         OP_XNOR:  w_alu = ~(w_op1 ^ w_op2);
         default:  w_alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= S_IDLE;
      else r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = (r_state == S_IDLE) ? ((w_accept && w_is_cnt) ? S_COUNT : S_IDLE)
                                        : (w_drain_ok ? S_IDLE : S_COUNT);
   end

   // a finished count waits in COUNT until the output register can take it
   always_comb begin
      w_drain_ok = !r_valid || ready_i;
      ready_o    = (r_state == S_IDLE) && w_drain_ok;
      w_load     = (r_state == S_COUNT) ? w_drain_ok : (w_accept && !w_is_cnt);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_valid  <= 1'b0;
         r_res    <= '0;
         r_ill    <= 1'b0;
         r_cnt_op <= '0;
      end else begin
         if (w_accept && w_is_cnt) r_cnt_op <= op_i;
         if (w_load) begin
            r_valid <= 1'b1;
            r_res   <= (r_state == S_COUNT) ? XLEN'(w_cnt_res) : w_alu;
            r_ill   <= (r_state == S_COUNT) ? 1'b0 : w_alu_ill;
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign valid_o   = r_valid;
   assign res_o     = r_res;
   assign illegal_o = r_ill;

endmodule

// File: tb/tb_zbb_exec_unit.sv
// tb_zbb_exec_unit: directed and randomized checks of zbb_exec_unit (XLEN=32) against a behavioural model
module tb_zbb_exec_unit;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b1;
   logic        imm_sel_i = 1'b0;
   logic [4:0]  op_i = '0;
   logic [1:0]  fwd_a_sel_i = '0;
   logic [1:0]  fwd_b_sel_i = '0;
   logic [31:0] instr_word_i = '0;
   logic [31:0] rs1_i = '0, rs2_i = '0, imm_i = '0, ex_mem_i = '0, mem_wb_i = '0;
   logic        ready_o, valid_o, illegal_o;
   logic [31:0] res_o;
   int          checks = 0;
   int          errors = 0;

   zbb_exec_unit #(.XLEN(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .op_i         (op_i),
      .instr_word_i (instr_word_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .imm_i        (imm_i),
      .ex_mem_i     (ex_mem_i),
      .mem_wb_i     (mem_wb_i),
      .fwd_a_sel_i  (fwd_a_sel_i),
      .fwd_b_sel_i  (fwd_b_sel_i),
      .imm_sel_i    (imm_sel_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .res_o        (res_o),
      .illegal_o    (illegal_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r, mw, ex);
      case (s)
         2'd0:    return r;
         2'd1:    return mw;
         2'd2:    return ex;
         default: return 32'h0;
      endcase
   endfunction

   // returns {illegal, result}
   function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, b, input logic [4:0] sh);
      logic [31:0] r;
      logic        ill;
      int          n;
      r = '0;
      ill = 1'b0;
      n = 0;
      case (op)
         5'd0: r = '0;
         5'd1: begin while (n < 32 && !a[31-n]) n++; r = 32'(n); end
         5'd2: begin while (n < 32 && !a[n]) n++; r = 32'(n); end
         5'd3, 5'd16: r = 32'($countones(a));
         5'd4: r = (b < a) ? b : a;
         5'd5: r = (b > a) ? b : a;
         5'd6: r = 32'($signed(a[15:0]));
         5'd7: r = 32'($signed(a[7:0]));
         5'd8: r = ($signed(b) > $signed(a)) ? b : a;
         5'd9: r = ($signed(b) < $signed(a)) ? b : a;
         5'd10: r = a & 32'h0000_FFFF;
`ifdef ZBB_ROT_EN
         5'd11, 5'd12, 5'd13: begin
            r = a;
            n = (op == 5'd13) ? int'(sh) : int'(b[4:0]);
            repeat (n) r = (op == 5'd11) ? {r[30:0], r[31]} : {r[0], r[31:1]};
         end
`endif
         5'd14: for (int k = 0; k < 4; k++) r[8*k +: 8] = (a[8*k +: 8] != 8'h0) ? 8'hFF : 8'h00;
         5'd15: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
         5'd17: r = a & ~b;
         5'd18: r = a | ~b;
         5'd19: r = ~(a ^ b);
         default: ill = 1'b1;
      endcase
      return {ill, r};
   endfunction

   task automatic issue(input logic [4:0] op, input logic [1:0] fa, fb, input logic isel,
                        input logic [31:0] r1, r2, im, ex, mw, input logic [4:0] sh, input string tag);
      logic [31:0] a, b;
      logic [32:0] exp;
      a = pick(fa, r1, mw, ex);
      b = isel ? im : pick(fb, r2, mw, ex);
      exp = model(op, a, b, sh);
      op_i = op; fwd_a_sel_i = fa; fwd_b_sel_i = fb; imm_sel_i = isel;
      rs1_i = r1; rs2_i = r2; imm_i = im; ex_mem_i = ex; mem_wb_i = mw;
      instr_word_i = $urandom;
      instr_word_i[24:20] = sh;
      valid_i = 1'b1;
      #1;
      check({tag, "_rdy"}, 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      rs1_i = $urandom; rs2_i = $urandom; imm_i = $urandom; ex_mem_i = $urandom; mem_wb_i = $urandom;
      if (op inside {5'd1, 5'd2, 5'd3, 5'd16}) begin
         check({tag, "_lat1_v"}, 64'(valid_o), 64'd0);
         check({tag, "_busy"}, 64'(ready_o), 64'd0);
         @(posedge clk); #1;
      end
      check({tag, "_v"}, 64'(valid_o), 64'd1);
      check({tag, "_res"}, 64'(res_o), 64'(exp[31:0]));
      check({tag, "_ill"}, 64'(illegal_o), 64'(exp[32]));
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] r1, r2);
      op_i = op; fwd_a_sel_i = 2'd0; fwd_b_sel_i = 2'd0; imm_sel_i = 1'b0;
      rs1_i = r1; rs2_i = r2; ex_mem_i = $urandom; mem_wb_i = $urandom;
      valid_i = 1'b1;
   endtask

   initial begin
      logic [31:0] r1, r2;
      logic [32:0] exp;
      // reset held two cycles with an offered op
      op_i = 5'd1; rs1_i = 32'h0000_0F00; valid_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_v", 64'(valid_o), 64'd0);
      check("rst_res", 64'(res_o), 64'd0);
      check("rst_ill", 64'(illegal_o), 64'd0);
      rst_ni = 1'b1; valid_i = 1'b0;
      @(posedge clk); #1;
      check("rst_rdy", 64'(ready_o), 64'd1);
      check("rst_v2", 64'(valid_o), 64'd0);

      issue(5'd1, 2'd0, 2'd0, 1'b0, 32'h0000_0F00, 0, 0, 0, 0, 0, "clz");
      check("clz_20", 64'(res_o), 64'd20);
      issue(5'd1, 2'd0, 2'd0, 1'b0, 32'h0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "clz0");
      check("clz0_32", 64'(res_o), 64'd32);
      issue(5'd2, 2'd0, 2'd0, 1'b0, 32'h0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "ctz0");
      check("ctz0_32", 64'(res_o), 64'd32);
      issue(5'd3, 2'd0, 2'd0, 1'b0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, "cpop");
      check("cpop_32", 64'(res_o), 64'd32);
      issue(5'd16, 2'd1, 2'd0, 1'b0, 0, 0, 0, 0, 32'h8000_0001, 0, "cpop16");
      check("cpop16_2", 64'(res_o), 64'd2);
      issue(5'd2, 2'd0, 2'd0, 1'b0, 32'h8000_0000, 0, 0, 0, 0, 0, "ctz31");
      check("ctz31_v", 64'(res_o), 64'd31);

      issue(5'd8, 2'd2, 2'd0, 1'b0, 32'h5, 32'h1, 0, 32'hFFFF_FFFF, 0, 0, "max_fwd");
      check("max_fwd_1", 64'(res_o), 64'd1);
      issue(5'd4, 2'd2, 2'd0, 1'b0, 32'h5, 32'h1, 0, 32'hFFFF_FFFF, 0, 0, "minu_fwd");
      check("minu_fwd_1", 64'(res_o), 64'd1);
      issue(5'd9, 2'd0, 2'd0, 1'b1, 32'h8000_0000, 0, 32'h8000_0000, 0, 0, 0, "min_eq");
      issue(5'd5, 2'd3, 2'd0, 1'b0, 32'h7, 32'h0, 0, 0, 0, 0, "maxu_zero");

      // back-pressure: result must hold, and the waiting op enters on release
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      drive(5'd14, 32'h0010_0000, 32'h0);
      #1;
      check("bp_rdy0", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      r1 = 32'hF0F0_1234; r2 = 32'h0F0F_0034;
      drive(5'd17, r1, r2);
      exp = model(5'd17, r1, r2, 5'd0);
      repeat (3) begin
         check("bp_v", 64'(valid_o), 64'd1);
         check("bp_res", 64'(res_o), 64'h00FF_0000);
         check("bp_rdy", 64'(ready_o), 64'd0);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      #1;
      check("bp_rel_rdy", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check("bp_next_v", 64'(valid_o), 64'd1);
      check("bp_next_res", 64'(res_o), 64'(exp[31:0]));

      issue(5'd13, 2'd0, 2'd0, 1'b0, 32'h1234_5678, 0, 0, 0, 0, 5'd4, "rori");
`ifdef ZBB_ROT_EN
      check("rori_const", 64'(res_o), 64'h8123_4567);
      check("rori_legal", 64'(illegal_o), 64'd0);
`else
      check("rori_const", 64'(res_o), 64'd0);
      check("rori_illegal", 64'(illegal_o), 64'd1);
`endif
      issue(5'd12, 2'd0, 2'd0, 1'b1, 32'hDEAD_BEEF, 0, 32'h20, 0, 0, 0, "ror0");
      issue(5'd11, 2'd0, 2'd0, 1'b0, 32'h8000_0001, 32'h1, 0, 0, 0, 0, "rol1");
      issue(5'd25, 2'd0, 2'd0, 1'b0, 32'h1234_5678, 32'h1, 0, 0, 0, 0, "op25");
      check("op25_ill", 64'(illegal_o), 64'd1);

      // a count in flight is dropped by reset
      drive(5'd3, 32'hFFFF_FFFF, 32'h0);
      @(posedge clk); #1;
      valid_i = 1'b0; rst_ni = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      check("rstcnt_v", 64'(valid_o), 64'd0);
      check("rstcnt_rdy", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      check("rstcnt_v2", 64'(valid_o), 64'd0);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a0;
         a0 = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF :
              ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
         r2 = ($urandom_range(0, 7) == 0) ? a0 : $urandom;
         issue(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a0, r2, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
